rsp_skid_pipe: RTL

Fully registered two-entry pipeline slice for the response channel of the valid/ready bus. It carries response beats from the slave end back toward the master end. Both the forward path (valid/data) and the backward path (ready) are cut by flops, so no combinational path crosses the block in either direction. It sustains one beat per cycle and reports its occupancy and the number of delivered beats.

---
 rtl/rsp_skid_pipe_if.sv | 21 ++
 rtl/rsp_skid_pipe.sv | 74 +++++++
 2 files changed

// File: rtl/rsp_skid_pipe_if.sv
// rsp_skid_pipe_if: response-channel valid/ready bundle between the slave side and the master side of the slice
interface rsp_skid_pipe_if #(
    parameter int DW = 3
);
    logic          rsp_valid_in;
    logic [DW-1:0] rsp_data_in;
    logic          rsp_ready_out;
    logic          rsp_valid_out;
    logic [DW-1:0] rsp_data_out;
    logic          rsp_ready_in;

    modport slave (
        input  rsp_valid_in, rsp_data_in, rsp_ready_in,
        output rsp_ready_out, rsp_valid_out, rsp_data_out
    );

    modport master (
        output rsp_valid_in, rsp_data_in, rsp_ready_in,
        input  rsp_ready_out, rsp_valid_out, rsp_data_out
    );
endinterface

// File: rtl/rsp_skid_pipe.sv
// rsp_skid_pipe: fully registered two-entry skid slice for response beats with occupancy and delivered-beat count
module rsp_skid_pipe #(
    parameter int DW = 3,
    parameter int CW = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    rsp_skid_pipe_if.slave bus,
    output logic [1:0]    occupancy,
    output logic [CW-1:0] beat_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          ready_q, ready_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_fire, out_fire;

    assign in_fire  = bus.rsp_valid_in && ready_q;
    assign out_fire = (state_q != EMPTY) && bus.rsp_ready_in;

    // Next state and storage moves; ready is registered from the next state so it never sees rsp_ready_in combinationally
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: if (in_fire) begin
                main_d  = bus.rsp_data_in;
                state_d = ONE;
            end
            ONE: if (in_fire && out_fire) begin
                main_d = bus.rsp_data_in;
            end else if (in_fire) begin
                skid_d  = bus.rsp_data_in;
                state_d = FULL;
            end else if (out_fire) begin
                state_d = EMPTY;
            end
            FULL: if (out_fire) begin
                main_d  = skid_q;
                state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
        ready_d = state_d != FULL;
        cnt_d   = cnt_q + CW'(out_fire);
    end

    // State registers; reset discards buffered beats and wins over any fire at the same edge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.rsp_ready_out = ready_q;
    assign bus.rsp_valid_out = state_q != EMPTY;
    assign bus.rsp_data_out  = main_q;
    assign occupancy         = state_q;
    assign beat_cnt          = cnt_q;
endmodule
